// File: rtl/int_arbiter.sv
// Interrupt request arbiter: synchronises three sources, latches rising edges as
// pending requests and issues a one-cycle take when a request outranks the active level.
module int_arbiter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NEST_DEPTH  = 3
) (
  input  logic       in_CLK,
  input  logic       in_RST,
  input  logic [2:0] in_irq,
  input  logic [2:0] in_mask,
  input  logic       in_NIE,
  input  logic       in_stall,
  input  logic       in_eret,
  output logic       out_BK,
  output logic [1:0] out_code,
  output logic [2:0] out_pending,
  output logic [1:0] out_level,
  output logic [1:0] out_depth
);

  localparam int unsigned NSRC = 3;
  localparam int unsigned SW   = SYNC_STAGES * NSRC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TAKE = 1'b1
  } state_t;

  state_t          state_q, state_n;
  logic [SW-1:0]   sync_q;
  logic [NSRC-1:0] sync_out;
  logic [NSRC-1:0] edge_q;
  logic [NSRC-1:0] rise_q;
  logic [NSRC-1:0] elig_c;
  logic [NSRC-1:0] clr_c;
  logic [1:0]      cand_c;
  logic [1:0]      code_n;
  logic [1:0]      below_c;
  logic [1:0]      stk0_q, stk1_q;
  logic            bk_n;
  logic            push_c;
  logic            pop_c;

  assign sync_out = sync_q[SW-1 -: NSRC];

  // Synchroniser chain, then a registered rising-edge pulse per source
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      sync_q <= '0;
      edge_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= SW'({sync_q, in_irq});
      edge_q <= sync_out;
      rise_q <= sync_out & ~edge_q;
    end
  end

  // Highest-code unmasked pending request
  always_comb begin
    elig_c = out_pending & ~in_mask;
    cand_c = 2'd0;
    if (elig_c[2])      cand_c = 2'd3;
    else if (elig_c[1]) cand_c = 2'd2;
    else if (elig_c[0]) cand_c = 2'd1;
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    bk_n    = 1'b0;
    code_n  = out_code;
    push_c  = 1'b0;
    clr_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if ((cand_c != 2'd0) && (cand_c > out_level) && in_NIE && !in_stall &&
            !in_eret && (32'(out_depth) < NEST_DEPTH)) begin
          bk_n    = 1'b1;
          code_n  = cand_c;
          push_c  = 1'b1;
          clr_c   = 3'b001 << (cand_c - 2'd1);
          state_n = ST_TAKE;
        end
      end
      ST_TAKE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Top of stack lives in out_level; only the entries below it are stored
  assign pop_c = in_eret && (out_depth != 2'd0);

  always_comb begin
    case (out_depth)
      2'd2:    below_c = stk0_q;
      2'd3:    below_c = stk1_q;
      default: below_c = 2'd0;
    endcase
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      out_BK      <= 1'b0;
      out_code    <= 2'd0;
      out_pending <= '0;
      out_level   <= 2'd0;
      out_depth   <= 2'd0;
      stk0_q      <= 2'd0;
      stk1_q      <= 2'd0;
    end else begin
      out_BK      <= bk_n;
      out_code    <= code_n;
      out_pending <= (out_pending & ~clr_c) | rise_q;
      if (push_c) begin
        if (out_depth == 2'd0)      stk0_q <= cand_c;
        else if (out_depth == 2'd1) stk1_q <= cand_c;
        out_level <= cand_c;
        out_depth <= out_depth + 2'd1;
      end else if (pop_c) begin
        out_level <= below_c;
        out_depth <= out_depth - 2'd1;
      end
    end
  end

endmodule
